// File: rtl/bram_pipe_accessor_pkg.sv
// Shared FSM state encoding and run-mode constants for the BRAM pipe accessor.
package bram_pipe_accessor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_COPY   = 2'b00;
   localparam logic [1:0] MODE_SQUARE = 2'b01;
   localparam logic [1:0] MODE_ACC    = 2'b10;

endpackage

// File: rtl/bram_pipe_accessor_if.sv
// Bundle of the two BRAM ports: BRAM0 is the read source, BRAM1 the write sink.
interface bram_pipe_accessor_if #(
   parameter int AWIDTH   = 8,
   parameter int DWIDTH_1 = 32,
   parameter int DWIDTH_2 = 64
);
   logic [AWIDTH-1:0]   addr_b0;
   logic                ce_b0;
   logic                we_b0;
   logic [DWIDTH_1-1:0] d_b0;
   logic [DWIDTH_1-1:0] q_b0;
   logic [AWIDTH-1:0]   addr_b1;
   logic                ce_b1;
   logic                we_b1;
   logic [DWIDTH_2-1:0] d_b1;

   // accessor side of both memories
   modport master (output addr_b0, ce_b0, we_b0, d_b0, addr_b1, ce_b1, we_b1, d_b1,
                   input  q_b0);
   // memory side
   modport slave  (input  addr_b0, ce_b0, we_b0, d_b0, addr_b1, ce_b1, we_b1, d_b1,
                   output q_b0);
   // write-back datapath: consumes read data, owns the BRAM1 port
   modport dp     (input  q_b0,
                   output addr_b1, ce_b1, we_b1, d_b1);
endinterface

// File: rtl/bram_pipe_accessor_datapath.sv
// Write-back datapath: mode mux, squarer, accumulator and registered BRAM1 port.
module bram_pipe_datapath
   import bram_pipe_accessor_pkg::*;
#(
   parameter int AWIDTH   = 8,
   parameter int DWIDTH_1 = 32,
   parameter int DWIDTH_2 = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr_i,
   input  logic              vld_i,
   input  logic [1:0]        mode_i,
   input  logic [AWIDTH-1:0] wr_addr_i,
   bram_pipe_accessor_if.dp  bus
);
   logic [DWIDTH_2-1:0] acc_q, acc_d;
   logic [DWIDTH_2-1:0] d_q, d_d;
   logic [AWIDTH-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DWIDTH_2-1:0] q_ext;

   assign q_ext = DWIDTH_2'(bus.q_b0);

   // form the next write beat from the consumed read data; d holds between beats
   always_comb begin
      acc_d  = acc_q;
      d_d    = d_q;
      addr_d = addr_q;
      we_d   = vld_i;
      if (clr_i) acc_d = '0;
      if (vld_i) begin
         addr_d = wr_addr_i;
         case (mode_i)
            MODE_SQUARE: d_d = q_ext * q_ext;
            MODE_ACC: begin
               acc_d = acc_q + q_ext;
               d_d   = acc_q + q_ext;
            end
            default:     d_d = q_ext;
         endcase
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         d_q    <= '0;
         addr_q <= '0;
         we_q   <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         d_q    <= d_d;
         addr_q <= addr_d;
         we_q   <= we_d;
      end
   end

   assign bus.ce_b1   = we_q;
   assign bus.we_b1   = we_q;
   assign bus.addr_b1 = addr_q;
   assign bus.d_b1    = d_q;

endmodule

// File: rtl/bram_pipe_accessor.sv
// Streams count words out of BRAM0, transforms them and writes them to BRAM1.
//
//   state | meaning
//   IDLE  | waiting for start_run_i; run parameters latched on start
//   RUN   | one BRAM0 read issued per cycle, remaining-count down-counter runs
//   DRAIN | reads finished, waiting for in-flight data to be written
//   DONE  | single-cycle done_o pulse
module bram_pipe_accessor
   import bram_pipe_accessor_pkg::*;
#(
   parameter int CNT_BIT  = 31,
   parameter int DWIDTH_1 = 32,
   parameter int DWIDTH_2 = 64,
   parameter int AWIDTH   = 8,
   parameter int RD_LAT   = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_run_i,
   input  logic [CNT_BIT-1:0]  run_count_i,
   input  logic [1:0]          mode_i,
   input  logic [AWIDTH-1:0]   base_b0_i,
   input  logic [AWIDTH-1:0]   base_b1_i,
   input  logic [DWIDTH_1-1:0] q_b0_i,
   output logic                idle_o,
   output logic                read_o,
   output logic                write_o,
   output logic                done_o,
   output logic [AWIDTH-1:0]   addr_b0_o,
   output logic                ce_b0_o,
   output logic                we_b0_o,
   output logic [DWIDTH_1-1:0] d_b0_o,
   output logic [AWIDTH-1:0]   addr_b1_o,
   output logic                ce_b1_o,
   output logic                we_b1_o,
   output logic [DWIDTH_2-1:0] d_b1_o
);
   state_t             state_q, state_d;
   logic [CNT_BIT-1:0] rem_q, rem_d;
   logic [AWIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic [AWIDTH-1:0]  wr_addr_q, wr_addr_d;
   logic [1:0]         mode_q, mode_d;
   logic [RD_LAT-1:0]  vld_q, vld_d;
   logic               rd_en;
   logic               clr_acc;
   logic               consume;

   bram_pipe_accessor_if #(.AWIDTH(AWIDTH), .DWIDTH_1(DWIDTH_1), .DWIDTH_2(DWIDTH_2)) bus ();

   assign rd_en   = (state_q == RUN);
   assign consume = vld_q[RD_LAT-1];

   // next state, address counters and read-valid pipe
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      mode_d    = mode_q;
      clr_acc   = 1'b0;
      vld_d[0]  = rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
      if (consume) wr_addr_d = wr_addr_q + AWIDTH'(1);
      case (state_q)
         IDLE: begin
            if (start_run_i) begin
               mode_d    = mode_i;
               rd_addr_d = base_b0_i;
               wr_addr_d = base_b1_i;
               rem_d     = run_count_i;
               clr_acc   = 1'b1;
               state_d   = (run_count_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            rd_addr_d = rd_addr_q + AWIDTH'(1);
            rem_d     = rem_q - CNT_BIT'(1);
            if (rem_q == CNT_BIT'(1)) state_d = DRAIN;
         end
         // the pipe empties in the same cycle the final write is on the bus
         DRAIN: if (vld_q == '0) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // control registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         mode_q    <= MODE_COPY;
         vld_q     <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         mode_q    <= mode_d;
         vld_q     <= vld_d;
      end
   end

   assign bus.addr_b0 = rd_addr_q;
   assign bus.ce_b0   = rd_en;
   assign bus.we_b0   = 1'b0;
   assign bus.d_b0    = '0;
   assign bus.q_b0    = q_b0_i;

   bram_pipe_datapath #(
      .AWIDTH   (AWIDTH),
      .DWIDTH_1 (DWIDTH_1),
      .DWIDTH_2 (DWIDTH_2)
   ) u_dp (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr_i     (clr_acc),
      .vld_i     (consume),
      .mode_i    (mode_q),
      .wr_addr_i (wr_addr_q),
      .bus       (bus)
   );

   assign idle_o    = (state_q == IDLE);
   assign read_o    = rd_en;
   assign write_o   = bus.we_b1;
   assign done_o    = (state_q == DONE);
   assign addr_b0_o = bus.addr_b0;
   assign ce_b0_o   = bus.ce_b0;
   assign we_b0_o   = bus.we_b0;
   assign d_b0_o    = bus.d_b0;
   assign addr_b1_o = bus.addr_b1;
   assign ce_b1_o   = bus.ce_b1;
   assign we_b1_o   = bus.we_b1;
   assign d_b1_o    = bus.d_b1;

endmodule
